vrf_read_responder: RTL and testbench

Serving end of the VRF read-request path. Accepts arbitrated read requests (vs, group offset, readSource, instructionIndex), issues them to a fixed-latency VRF bank read port, and captures the returned data with its tag. Returns data to the requesting source over a valid/ready response channel, in request order. Credit-based admission guarantees the response queue never overflows, so returning bank data never needs backpressure.

---
 rtl/vrf_read_responder.sv | 142 ++++++++++++++
 tb/tb_vrf_read_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_read_responder.sv
// rtl/vrf_read_responder.sv - VRF read serving end: fixed-latency bank read, tag pipe, credit-guarded response FIFO.
// Optional VRF_READ_PARITY_EN adds per-entry parity error tracking and a sticky error flag.
module vrf_read_responder #(
   parameter int READ_LATENCY = 2,
   parameter int QUEUE_DEPTH  = 4,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_req_valid,
   output logic                  io_req_ready,
   input  logic [4:0]            io_req_bits_vs,
   input  logic [3:0]            io_req_bits_groupIndex,
   input  logic [3:0]            io_req_bits_readSource,
   input  logic [2:0]            io_req_bits_instructionIndex,
   output logic                  vrf_read_en,
   output logic [8:0]            vrf_read_addr,
   input  logic [DATA_WIDTH-1:0] vrf_read_data,
`ifdef VRF_READ_PARITY_EN
   input  logic                  vrf_read_parity,
   output logic                  io_resp_bits_parityError,
   output logic                  io_parityError,
`endif
   output logic                  io_resp_valid,
   input  logic                  io_resp_ready,
   output logic [DATA_WIDTH-1:0] io_resp_bits_data,
   output logic [3:0]            io_resp_bits_readSource,
   output logic [2:0]            io_resp_bits_instructionIndex
);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

   logic [CW-1:0]           outstanding;
   logic [CW-1:0]           fifo_cnt;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [READ_LATENCY-1:0] pipe_v;
   logic [3:0]              pipe_src [READ_LATENCY];
   logic [2:0]              pipe_idx [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   mem_data [QUEUE_DEPTH];
   logic [3:0]              mem_src  [QUEUE_DEPTH];
   logic [2:0]              mem_idx  [QUEUE_DEPTH];
   logic                    req_fire;
   logic                    resp_fire;
   logic                    push;

   // Credits count everything not yet handed back, so the FIFO can never be pushed while full.
   assign io_req_ready  = (outstanding < CW'(QUEUE_DEPTH));
   assign req_fire      = io_req_valid & io_req_ready;
   assign vrf_read_en   = req_fire;
   assign vrf_read_addr = req_fire ? {io_req_bits_vs, io_req_bits_groupIndex} : 9'd0;
   assign push          = pipe_v[READ_LATENCY-1];
   assign io_resp_valid = (fifo_cnt != '0);
   assign resp_fire     = io_resp_valid & io_resp_ready;

   assign io_resp_bits_data             = mem_data[rd_ptr];
   assign io_resp_bits_readSource       = mem_src[rd_ptr];
   assign io_resp_bits_instructionIndex = mem_idx[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding <= '0;
      end else begin
         case ({req_fire, resp_fire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pipe_v <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_src[i] <= '0;
            pipe_idx[i] <= '0;
         end
      end else begin
         pipe_v[0]   <= req_fire;
         pipe_src[0] <= io_req_bits_readSource;
         pipe_idx[0] <= io_req_bits_instructionIndex;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_src[i] <= pipe_src[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_src[i]  <= '0;
            mem_idx[i]  <= '0;
         end
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= vrf_read_data;
            mem_src[wr_ptr]  <= pipe_src[READ_LATENCY-1];
            mem_idx[wr_ptr]  <= pipe_idx[READ_LATENCY-1];
            wr_ptr <= (wr_ptr == PW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (resp_fire) begin
            rd_ptr <= (rd_ptr == PW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, resp_fire})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

`ifdef VRF_READ_PARITY_EN
   logic mem_perr [QUEUE_DEPTH];
   logic sticky;

   assign io_resp_bits_parityError = mem_perr[rd_ptr];
   assign io_parityError           = sticky;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sticky <= 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++) mem_perr[i] <= 1'b0;
      end else begin
         if (push) mem_perr[wr_ptr] <= (^vrf_read_data) ^ vrf_read_parity;
         if (resp_fire && mem_perr[rd_ptr]) sticky <= 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset) assert (!(push && fifo_cnt == CW'(QUEUE_DEPTH) && !resp_fire));
   end
`endif
endmodule

// File: tb/tb_vrf_read_responder.sv
// tb/tb_vrf_read_responder.sv - directed and random checks against a queue-based reference model.
module tb_vrf_read_responder;
   localparam int L  = 2;
   localparam int QD = 4;

   logic        clock;
   logic        reset;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [4:0]  io_req_bits_vs;
   logic [3:0]  io_req_bits_groupIndex;
   logic [3:0]  io_req_bits_readSource;
   logic [2:0]  io_req_bits_instructionIndex;
   logic        vrf_read_en;
   logic [8:0]  vrf_read_addr;
   logic [31:0] vrf_read_data;
   logic        io_resp_valid;
   logic        io_resp_ready;
   logic [31:0] io_resp_bits_data;
   logic [3:0]  io_resp_bits_readSource;
   logic [2:0]  io_resp_bits_instructionIndex;
`ifdef VRF_READ_PARITY_EN
   logic        vrf_read_parity;
   logic        io_resp_bits_parityError;
   logic        io_parityError;
`endif

   vrf_read_responder #(.READ_LATENCY(L), .QUEUE_DEPTH(QD), .DATA_WIDTH(32)) dut (
      .clock(clock),
      .reset(reset),
      .io_req_valid(io_req_valid),
      .io_req_ready(io_req_ready),
      .io_req_bits_vs(io_req_bits_vs),
      .io_req_bits_groupIndex(io_req_bits_groupIndex),
      .io_req_bits_readSource(io_req_bits_readSource),
      .io_req_bits_instructionIndex(io_req_bits_instructionIndex),
      .vrf_read_en(vrf_read_en),
      .vrf_read_addr(vrf_read_addr),
      .vrf_read_data(vrf_read_data),
`ifdef VRF_READ_PARITY_EN
      .vrf_read_parity(vrf_read_parity),
      .io_resp_bits_parityError(io_resp_bits_parityError),
      .io_parityError(io_parityError),
`endif
      .io_resp_valid(io_resp_valid),
      .io_resp_ready(io_resp_ready),
      .io_resp_bits_data(io_resp_bits_data),
      .io_resp_bits_readSource(io_resp_bits_readSource),
      .io_resp_bits_instructionIndex(io_resp_bits_instructionIndex)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  src;
      logic [2:0]  idx;
      bit          perr;
      int          avail;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          out_cnt = 0;
   int          nfire = 0;
   int          n0;
   bit          exp_sticky = 0;
   bit          inject_bad = 0;
   bit          bank_v   [8];
   bit          bank_bad [8];
   logic [31:0] bank_d   [8];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs and the bank, compare DUT against the model, then advance the model.
   task automatic step(input bit rv, input logic [4:0] vs, input logic [3:0] gi,
                       input logic [3:0] src, input logic [2:0] idx, input bit rr,
                       input logic [31:0] d);
      int  slot;
      bit  exp_rdy, fire, exp_rv;
      logic [8:0] exp_addr;
      @(negedge clock);
      io_req_valid = rv;
      io_req_bits_vs = vs;
      io_req_bits_groupIndex = gi;
      io_req_bits_readSource = src;
      io_req_bits_instructionIndex = idx;
      io_resp_ready = rr;
      slot = cyc % 8;
      if (bank_v[slot]) begin
         vrf_read_data = bank_d[slot];
`ifdef VRF_READ_PARITY_EN
         vrf_read_parity = (^bank_d[slot]) ^ bank_bad[slot];
`endif
         bank_v[slot] = 0;
      end else begin
         vrf_read_data = $urandom;
`ifdef VRF_READ_PARITY_EN
         vrf_read_parity = 1'($urandom);
`endif
      end
      #1;
      exp_rdy  = (out_cnt < QD);
      fire     = rv && exp_rdy;
      exp_addr = fire ? {vs, gi} : 9'd0;
      exp_rv   = (q.size() > 0) && (q[0].avail <= cyc);
      check("req_ready", io_req_ready, exp_rdy);
      check("read_en", vrf_read_en, fire);
      check("read_addr", vrf_read_addr, exp_addr);
      check("resp_valid", io_resp_valid, exp_rv);
      if (exp_rv) begin
         check("resp_data", io_resp_bits_data, q[0].d);
         check("resp_src", io_resp_bits_readSource, q[0].src);
         check("resp_idx", io_resp_bits_instructionIndex, q[0].idx);
`ifdef VRF_READ_PARITY_EN
         check("resp_perr", io_resp_bits_parityError, q[0].perr);
`endif
      end
`ifdef VRF_READ_PARITY_EN
      check("sticky_perr", io_parityError, exp_sticky);
`endif
      if (fire) begin
         q.push_back('{d, src, idx, inject_bad, cyc + L + 1});
         bank_v[(cyc + L) % 8]   = 1;
         bank_d[(cyc + L) % 8]   = d;
         bank_bad[(cyc + L) % 8] = inject_bad;
         out_cnt++;
         nfire++;
      end
      if (exp_rv && rr) begin
         if (q[0].perr) exp_sticky = 1;
         void'(q.pop_front());
         out_cnt--;
      end
      cyc++;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) step(0, 5'd0, 4'd0, 4'd0, 3'd0, rr, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         bank_v[i] = 0;
         bank_bad[i] = 0;
         bank_d[i] = '0;
      end
      reset = 1'b0;
      io_req_valid = 0;
      io_req_bits_vs = '0;
      io_req_bits_groupIndex = '0;
      io_req_bits_readSource = '0;
      io_req_bits_instructionIndex = '0;
      io_resp_ready = 0;
      vrf_read_data = '0;
`ifdef VRF_READ_PARITY_EN
      vrf_read_parity = 0;
`endif
      #1;
      check("rst_req_ready", io_req_ready, 1);
      check("rst_resp_valid", io_resp_valid, 0);
      check("rst_read_en", vrf_read_en, 0);
      check("rst_read_addr", vrf_read_addr, 0);
      check("rst_resp_data", io_resp_bits_data, 0);
      check("rst_resp_src", io_resp_bits_readSource, 0);
      check("rst_resp_idx", io_resp_bits_instructionIndex, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      // Single read
      step(1, 5'd3, 4'd5, 4'd2, 3'd1, 1, 32'hDEADBEEF);
      idle(5, 1);

      // Fill with responses blocked, then drain
      n0 = nfire;
      for (int i = 0; i < 6; i++) step(1, 5'(i), 4'(i), 4'(i), 3'(i), 0, $urandom);
      check("fill_fires", nfire - n0, 4);
      idle(8, 1);
      check("fill_drained", out_cnt, 0);

      // Streaming
      n0 = nfire;
      for (int i = 0; i < 16; i++) step(1, 5'(i + 7), 4'(15 - i), 4'(i), 3'(i), 1, $urandom);
      check("stream_fires", nfire - n0, 16);
      idle(6, 1);

      // Full plus simultaneous accept/return, several wraps
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) step(1, 5'($urandom), 4'($urandom), 4'(i), 3'(r), 0, $urandom);
         for (int i = 0; i < 6; i++) step(1, 5'($urandom), 4'($urandom), 4'(i + 8), 3'(r), 1, $urandom);
      end
      idle(8, 1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, 5'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
              ($urandom % 3) != 0, $urandom);
      idle(10, 1);

      // Reset with one entry queued and two in the tag pipe
      for (int i = 0; i < 3; i++) step(1, 5'(i), 4'(i), 4'(i + 4), 3'(i), 0, $urandom);
      @(posedge clock);
      #1;
      io_req_valid = 0;
      reset = 1'b0;
      #1;
      check("midrst_resp_valid", io_resp_valid, 0);
      check("midrst_req_ready", io_req_ready, 1);
      check("midrst_read_en", vrf_read_en, 0);
      q.delete();
      out_cnt = 0;
      exp_sticky = 0;
      idle(2, 1);
      reset = 1'b1;
      idle(8, 1);
      step(1, 5'd9, 4'd9, 4'd9, 3'd6, 1, 32'h1234_5678);
      idle(5, 1);

`ifdef VRF_READ_PARITY_EN
      inject_bad = 1;
      step(1, 5'd1, 4'd1, 4'd3, 3'd2, 1, 32'h0000_0001);
      inject_bad = 0;
      idle(5, 1);
      check("perr_sticky_set", io_parityError, 1);
      for (int i = 0; i < 10; i++) step(1, 5'(i), 4'(i), 4'(i), 3'(i), 1, $urandom);
      idle(5, 1);
      check("perr_sticky_hold", io_parityError, 1);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("perr_sticky_clear", io_parityError, 0);
      q.delete();
      out_cnt = 0;
      exp_sticky = 0;
      idle(1, 1);
      reset = 1'b1;
      idle(4, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
